// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 8-bit core: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// ready stalls. Optional memory wait timeout is enabled by defining CU_TIMEOUT_EN.
module multicycle_control_unit #(
   parameter int unsigned OPCODE_W    = 2,
   parameter int unsigned ALUOP_W     = 2,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                instr_ready,
   input  logic                mem_ready,
   output logic [ALUOP_W-1:0]  ALUop,
   output logic                RegWrite,
   output logic                MemWrite,
   output logic                MemRead,
   output logic                ALUSrc,
   output logic                pc_en,
   output logic                busy,
   output logic                illegal_op,
   output logic                timeout
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4
   } state_t;

   localparam logic [1:0] OpR     = 2'b00;
   localparam logic [1:0] OpLoad  = 2'b01;
   localparam logic [1:0] OpStore = 2'b10;

   state_t              state_q;
   logic [OPCODE_W-1:0] op_q;
   logic [1:0]          op_lo;
   logic                legal;
   logic                is_mem_op;
   logic                timeout_hit;

   assign op_lo     = op_q[1:0];
   assign legal     = (op_q >> 2) == '0;
   assign is_mem_op = (op_lo == OpLoad) || (op_lo == OpStore);

`ifdef CU_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CntW-1:0] wait_q;

   // mem_ready in the final allowed cycle still counts as a normal completion
   assign timeout_hit = (state_q == StMem) && !mem_ready && (wait_q == CntW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q <= '0;
      end else if (state_q == StExec) begin
         wait_q <= '0;
      end else if (state_q == StMem && !mem_ready && !timeout_hit) begin
         wait_q <= wait_q + CntW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFetch;
         op_q    <= '0;
      end else begin
         case (state_q)
            StFetch: begin
               if (instr_valid) begin
                  op_q    <= opcode;
                  state_q <= StDecode;
               end
            end
            StDecode: state_q <= legal ? StExec : StFetch;
            StExec:   state_q <= is_mem_op ? StMem : StWb;
            StMem: begin
               if (mem_ready) begin
                  state_q <= (op_lo == OpLoad) ? StWb : StFetch;
               end else if (timeout_hit) begin
                  state_q <= StFetch;
               end
            end
            StWb:     state_q <= StFetch;
            default:  state_q <= StFetch;
         endcase
      end
   end

   // Moore decode of the registered state; only the MEM-cycle pc_en/timeout are qualified by
   // mem_ready, since a store retires in the same cycle memory acknowledges it.
   always_comb begin
      instr_ready = 1'b0;
      ALUop       = '0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
      ALUSrc      = 1'b0;
      pc_en       = 1'b0;
      illegal_op  = 1'b0;
      timeout     = 1'b0;
      case (state_q)
         StFetch:  instr_ready = 1'b1;
         StDecode: illegal_op  = !legal;
         StExec: begin
            ALUop  = (op_lo == OpR) ? ALUOP_W'(2) : '0;
            ALUSrc = (op_lo != OpR);
         end
         StMem: begin
            ALUSrc   = 1'b1;
            MemRead  = (op_lo == OpLoad);
            MemWrite = (op_lo == OpStore);
            pc_en    = (op_lo == OpStore) && mem_ready;
            timeout  = timeout_hit;
         end
         StWb: begin
            RegWrite = 1'b1;
            pc_en    = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = (state_q != StFetch);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: instruction-age model compared every cycle
// plus directed literal checks. Built with or without CU_TIMEOUT_EN.
module tb_multicycle_control_unit;

   localparam int unsigned TO = 4;
`ifdef CU_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic [2:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       instr_ready;
   logic [1:0] ALUop;
   logic       RegWrite, MemWrite, MemRead, ALUSrc, pc_en, busy, illegal_op, timeout;

   int checks = 0;
   int errors = 0;

   multicycle_control_unit #(
      .OPCODE_W   (3),
      .ALUOP_W    (2),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_valid(instr_valid),
      .opcode     (opcode),
      .instr_ready(instr_ready),
      .mem_ready  (mem_ready),
      .ALUop      (ALUop),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .ALUSrc     (ALUSrc),
      .pc_en      (pc_en),
      .busy       (busy),
      .illegal_op (illegal_op),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   // Model: an instruction is described by its opcode, its age since acceptance
   // (0 = decode cycle, 1 = execute cycle, 2+ = memory/writeback) and how many
   // memory cycles have elapsed.
   bit m_busy    = 1'b0;
   int m_op      = 0;
   int m_age     = 0;
   int m_memw    = 0;
   bit m_memdone = 1'b0;

   function automatic bit is_mem(input int op);
      return (op == 1) || (op == 2);
   endfunction

   function automatic logic [10:0] model_out(input logic mr);
      logic       ir, rw, mw, mrd, src, pc, bsy, ill, to;
      logic [1:0] alu;
      ir = 0; rw = 0; mw = 0; mrd = 0; src = 0; pc = 0; bsy = 0; ill = 0; to = 0; alu = 0;
      if (!m_busy) begin
         ir = 1;
      end else begin
         bsy = 1;
         if (m_age == 0) begin
            ill = (m_op > 3);
         end else if (m_age == 1) begin
            alu = (m_op == 0) ? 2'd2 : 2'd0;
            src = (m_op != 0);
         end else if (is_mem(m_op) && !m_memdone) begin
            src = 1;
            mrd = (m_op == 1);
            mw  = (m_op == 2);
            pc  = (m_op == 2) && mr;
            to  = TO_EN && (m_memw == TO - 1) && !mr;
         end else begin
            rw = 1;
            pc = 1;
         end
      end
      return {ir, alu, rw, mw, mrd, src, pc, bsy, ill, to};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
      end else if (!m_busy) begin
         if (instr_valid) begin
            m_busy    <= 1'b1;
            m_op      <= int'(opcode);
            m_age     <= 0;
            m_memw    <= 0;
            m_memdone <= 1'b0;
         end
      end else if (m_age == 0) begin
         if (m_op > 3) m_busy <= 1'b0;
         else m_age <= 1;
      end else if (m_age == 1) begin
         m_age <= 2;
      end else if (is_mem(m_op) && !m_memdone) begin
         if (mem_ready) begin
            if (m_op == 2) m_busy <= 1'b0;
            else m_memdone <= 1'b1;
         end else if (TO_EN && m_memw == TO - 1) begin
            m_busy <= 1'b0;
         end else begin
            m_memw <= m_memw + 1;
         end
      end else begin
         m_busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      logic [10:0] exp_v, act_v;
      exp_v = model_out(mem_ready);
      act_v = {instr_ready, ALUop, RegWrite, MemWrite, MemRead, ALUSrc, pc_en, busy,
               illegal_op, timeout};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL cycle_model t=%0t got %b expected %b", $time, act_v, exp_v);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op);
      instr_valid = 1'b1;
      opcode      = op;
      step();
      instr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst_instr_ready", instr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {RegWrite, MemWrite, MemRead, pc_en, ALUop}, 0);
      rst = 1'b0;
      step();

      // R-type: ALUop=2 at +2, RegWrite/pc_en at +3, ready at +4
      issue(3'd0);
      step();
      chk("r_exec_aluop", ALUop, 2);
      chk("r_exec_alusrc", ALUSrc, 0);
      step();
      chk("r_wb_regwrite", RegWrite, 1);
      chk("r_wb_pc_en", pc_en, 1);
      step();
      chk("r_done_ready", instr_ready, 1);

      // LOAD with three not-ready MEM cycles
      mem_ready = 1'b0;
      issue(3'd1);
      step();
      chk("ld_exec_alusrc", ALUSrc, 1);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("ld_mem_read", MemRead, 1);
         chk("ld_mem_alusrc", ALUSrc, 1);
         if (i == 3) mem_ready = 1'b1;
         step();
      end
      mem_ready = 1'b0;
      chk("ld_wb_regwrite", RegWrite, 1);
      chk("ld_wb_memread", MemRead, 0);
      step();
      chk("ld_done_ready", instr_ready, 1);

      // ADDI with instr_valid held high and opcode changing while busy
      instr_valid = 1'b1;
      opcode      = 3'd3;
      step();
      opcode = 3'd1;
      step();
      chk("addi_exec_alu", {ALUop, ALUSrc}, 3'b001);
      step();
      chk("addi_wb_regwrite", RegWrite, 1);
      instr_valid = 1'b0;
      step();
      chk("addi_done_idle", busy, 0);

      // STORE with mem_ready already high in EXEC and the first MEM cycle
      issue(3'd2);
      step();
      mem_ready = 1'b1;
      step();
      chk("st_mem_write", MemWrite, 1);
      chk("st_mem_pc_en", pc_en, 1);
      chk("st_no_regwrite", RegWrite, 0);
      step();
      mem_ready = 1'b0;
      chk("st_done_ready", instr_ready, 1);

      // Illegal opcode 3'b101
      issue(3'd5);
      chk("ill_pulse", illegal_op, 1);
      chk("ill_no_pc_en", pc_en, 0);
      step();
      chk("ill_back_fetch", instr_ready, 1);
      chk("ill_pulse_gone", illegal_op, 0);

      // LOAD held without mem_ready: times out on the 4th MEM cycle when enabled
      issue(3'd1);
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         chk("to_mem_read", MemRead, 1);
         chk("to_pulse", timeout, (TO_EN && i == 3) ? 1 : 0);
         step();
      end
      if (TO_EN) begin
         chk("to_back_fetch", instr_ready, 1);
         chk("to_no_regwrite", RegWrite, 0);
      end else begin
         chk("to_still_waiting", MemRead, 1);
         mem_ready = 1'b1;
         step();
         mem_ready = 1'b0;
         chk("to_late_wb", RegWrite, 1);
         step();
      end

      // Asynchronous reset in the middle of a LOAD's MEM phase
      issue(3'd1);
      step();
      step();
      step();
      #2 rst = 1'b1;
      #1;
      chk("arst_memread", MemRead, 0);
      chk("arst_ready", instr_ready, 1);
      #2 rst = 1'b0;
      step();
      chk("arst_idle", busy, 0);

      // Sweep every opcode with random memory acknowledge, checked by the model
      for (int op = 0; op < 8; op++) begin
         issue(3'(op));
         for (int c = 0; c < 30 && !instr_ready; c++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            step();
         end
         chk("sweep_done", instr_ready, 1);
         mem_ready = 1'b0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
